// File: rtl/pll_freq_lock_ctrl.sv
// Digital frequency-lock loop: counts synchronised feedback edges per
// reference window and steers a saturating DCO control word.
module pll_freq_lock_ctrl #(
  parameter int CTRL_W      = 8,
  parameter int CNT_W       = 12,
  parameter int WIN_CYC     = 4,
  parameter int LOCK_CNT    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              ref_in,
  input  logic              fb_in,
  input  logic [CNT_W-1:0]  mult,
  input  logic [1:0]        gain_sel,
  input  logic [3:0]        tol,
  output logic [CTRL_W-1:0] dco_ctrl,
  output logic              locked,
  output logic              err_valid,
  output logic [CNT_W:0]    err_out,
  output logic [1:0]        state
);

  localparam int RW = $clog2(WIN_CYC + 1);
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int SW =
    ((CTRL_W > CNT_W + 1) ? CTRL_W : CNT_W + 1) + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } state_t;

  state_t st, st_nx;

  logic [SYNC_STAGES-1:0] ref_sync, fb_sync;
  logic                   ref_old, fb_old;
  logic                   ref_rise, fb_rise;

  logic [RW-1:0]    ref_cnt;
  logic [CNT_W-1:0] fb_cnt, fb_sat, cap, mult_q;
  logic             upd, close;
  logic [LW-1:0]    lock_cnt, lock_nx;

  logic signed [CNT_W:0] err, sh, step;
  logic        [CNT_W:0] mag;
  logic                  in_tol;
  logic signed [SW-1:0]  sum;
  logic [CTRL_W-1:0]     dco_nx;

  assign ref_rise = ref_sync[SYNC_STAGES-1] & ~ref_old;
  assign fb_rise  = fb_sync[SYNC_STAGES-1] & ~fb_old;
  assign state    = st;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_sync <= '0;
      fb_sync  <= '0;
      ref_old  <= 1'b0;
      fb_old   <= 1'b0;
    end else begin
      ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_in};
      fb_sync  <= {fb_sync[SYNC_STAGES-2:0], fb_in};
      ref_old  <= ref_sync[SYNC_STAGES-1];
      fb_old   <= fb_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:    st_nx = ARM;
      ARM:     if (ref_rise) st_nx = COUNT;
      COUNT:   st_nx = COUNT;
      default: st_nx = IDLE;
    endcase
    if (!ena) st_nx = IDLE;
  end

  assign fb_sat = (&fb_cnt) ? fb_cnt : fb_cnt + 1'b1;
  assign close  = (st == COUNT) && ena && ref_rise &&
                  (ref_cnt == RW'(WIN_CYC - 1));

  // A feedback edge coincident with the closing reference edge
  // belongs to the window being closed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      fb_cnt  <= '0;
      cap     <= '0;
      mult_q  <= '0;
      upd     <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (st != COUNT || !ena) begin
        ref_cnt <= '0;
        fb_cnt  <= '0;
      end else if (close) begin
        cap     <= fb_rise ? fb_sat : fb_cnt;
        mult_q  <= mult;
        ref_cnt <= '0;
        fb_cnt  <= '0;
        upd     <= 1'b1;
      end else begin
        if (ref_rise) ref_cnt <= ref_cnt + RW'(1);
        if (fb_rise)  fb_cnt  <= fb_sat;
      end
    end
  end

  always_comb begin
    err  = $signed({1'b0, mult_q}) - $signed({1'b0, cap});
    sh   = err >>> gain_sel;
    step = sh;
    if (err != '0 && sh == '0)
      step = err[CNT_W] ? '1 : (CNT_W+1)'(1);
    sum = $signed({{(SW-CTRL_W){1'b0}}, dco_ctrl}) +
          $signed({{(SW-CNT_W-1){step[CNT_W]}}, step});
    if (sum[SW-1])
      dco_nx = '0;
    else if (|sum[SW-2:CTRL_W])
      dco_nx = '1;
    else
      dco_nx = sum[CTRL_W-1:0];
    mag     = err[CNT_W] ? -err : err;
    in_tol  = mag <= {{(CNT_W-3){1'b0}}, tol};
    lock_nx = '0;
    if (in_tol)
      lock_nx = (lock_cnt == LW'(LOCK_CNT)) ?
                lock_cnt : lock_cnt + LW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dco_ctrl  <= {1'b1, {(CTRL_W-1){1'b0}}};
      err_out   <= '0;
      err_valid <= 1'b0;
      lock_cnt  <= '0;
      locked    <= 1'b0;
    end else begin
      err_valid <= upd;
      if (upd) begin
        err_out  <= err;
        dco_ctrl <= dco_nx;
      end
      if (!ena || st == IDLE) begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end else if (upd) begin
        lock_cnt <= lock_nx;
        locked   <= (lock_nx == LW'(LOCK_CNT));
      end
    end
  end

endmodule

// File: tb/tb_pll_freq_lock_ctrl.sv
// Randomised bench for pll_freq_lock_ctrl with a window-level
// arithmetic model of error, gain step, saturation and lock.
module tb_pll_freq_lock_ctrl;

  localparam int PR  = 48;
  localparam int WIN = 4;
  localparam int LIM = 700;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        ref_in, fb_in;
  logic [11:0] mult = 12'd32;
  logic [1:0]  gain_sel = 2'd0;
  logic [3:0]  tol = 4'd0;
  logic [7:0]  dco_ctrl;
  logic        locked, err_valid;
  logic [12:0] err_out;
  logic [1:0]  state;

  int cyc = 0;
  int ratio = 8;
  int off = 0;
  int checks = 0;
  int failures = 0;
  int m_dco = 128;
  int m_lock = 0;

  pll_freq_lock_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .ref_in(ref_in), .fb_in(fb_in), .mult(mult),
    .gain_sel(gain_sel), .tol(tol), .dco_ctrl(dco_ctrl),
    .locked(locked), .err_valid(err_valid),
    .err_out(err_out), .state(state)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cyc = cyc + 1;

  assign ref_in = (cyc % PR) < PR / 2;
  assign fb_in  = ((cyc + off) % (PR / ratio)) < PR / ratio / 2;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_win(input int m);
    int err, step, d;
    err = m - ratio * WIN;
    d = 1 << gain_sel;
    if (err >= 0) step = err / d;
    else          step = -((-err + d - 1) / d);
    if (err != 0 && step == 0) step = (err > 0) ? 1 : -1;
    m_dco = m_dco + step;
    if (m_dco < 0)   m_dco = 0;
    if (m_dco > 255) m_dco = 255;
    if ((err < 0 ? -err : err) <= int'(tol))
      m_lock = (m_lock < 4) ? m_lock + 1 : 4;
    else
      m_lock = 0;
    chk("err_out", $signed(err_out), err);
  endtask

  task automatic check_win(input int m);
    int d0;
    model_win(m);
    chk("dco_ctrl", dco_ctrl, m_dco);
    chk("locked", locked, m_lock == 4 ? 1 : 0);
    d0 = dco_ctrl;
    @(negedge clk);
    chk("pulse", err_valid, 0);
    chk("dco_hold", dco_ctrl, d0);
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err_valid && n < LIM);
    ok = err_valid;
    if (!ok) chk("timeout", 0, 1);
  endtask

  task automatic win(input int m);
    bit ok;
    mult = 12'(m);
    wait_valid(ok);
    if (ok) check_win(m);
  endtask

  task automatic do_reset();
    int n = 0;
    while ((cyc % PR) != 26 && n < 2 * PR) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dco", dco_ctrl, 128);
    chk("rst_locked", locked, 0);
    chk("rst_valid", err_valid, 0);
    chk("rst_err", err_out, 0);
    chk("rst_state", state, 0);
    m_dco = 128;
    m_lock = 0;
    rst_n = 1'b1;
  endtask

  task automatic seg(input int r, input int g, input int t);
    ena = 1'b0;
    @(negedge clk);
    m_lock = 0;
    ratio = r;
    off = $urandom_range(0, PR / r - 1);
    gain_sel = 2'(g);
    tol = 4'(t);
    repeat (5) @(negedge clk);
    ena = 1'b1;
  endtask

  initial begin
    int rl[6] = '{2, 3, 4, 6, 8, 12};
    int n, nv, d0, base, m;
    bit ok;

    do_reset();
    seg(8, 0, 0);
    for (int i = 0; i < 5; i++) win(32);

    seg(6, 1, 0);
    for (int i = 0; i < 2; i++) win(32);

    do_reset();
    seg(8, 3, 0);
    win(33);
    win(31);
    win(31);

    seg(2, 0, 0);
    for (int i = 0; i < 8; i++) win(32);
    chk("sat_hi", dco_ctrl, 255);

    seg(12, 0, 0);
    for (int i = 0; i < 18; i++) win(32);
    chk("sat_lo", dco_ctrl, 0);

    do_reset();
    seg(8, 3, 1);
    for (int i = 0; i < 4; i++) win(31 + (i % 3));
    chk("lock_on", locked, 1);
    win(35);
    chk("lock_drop", locked, 0);
    for (int i = 0; i < 4; i++) win(32);
    chk("relock", locked, 1);

    repeat (60) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    chk("dis_state", state, 0);
    chk("dis_locked", locked, 0);
    m_lock = 0;
    d0 = dco_ctrl;
    nv = 0;
    repeat (300) begin
      @(negedge clk);
      if (err_valid) nv++;
    end
    chk("dis_novalid", nv, 0);
    chk("dis_dco", dco_ctrl, d0);
    ena = 1'b1;
    @(negedge clk);
    chk("arm_state", state, 1);
    n = 0;
    while (state != 2 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err_valid && n < LIM);
    chk("first_lat", n, WIN * PR + 1);
    if (err_valid) check_win(32);

    repeat (50) @(negedge clk);
    do_reset();
    win(34);
    win(30);

    for (int s = 0; s < 6; s++) begin
      seg(rl[$urandom_range(0, 5)], $urandom_range(0, 3),
          $urandom_range(0, 4));
      base = ratio * WIN;
      for (int w = 0; w < 3 + $urandom_range(0, 3); w++) begin
        m = base + $urandom_range(0, 40) - 20;
        if ($urandom_range(0, 1) == 1)
          m = base + $urandom_range(0, 6) - 3;
        if (m < 0) m = 0;
        win(m);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
